// File: rtl/shift_seq.sv
// shift_seq: byte serialiser driving an 8-bit universal shift register.
// Loads the byte once, then shifts seven times, one bit slot per BIT_CLKS clocks.
module shift_seq #(
  parameter int unsigned BIT_CLKS = 4,
  parameter logic        FILL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_msb_first,
  input  logic       abort,
  input  logic [7:0] sr_q,
  output logic [1:0] m,
  output logic [7:0] par_in,
  output logic       sl,
  output logic       sr,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       bit_start,
  output logic [2:0] bit_idx,
  output logic       busy,
  output logic       done
);

  localparam int TW = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam logic [TW-1:0] T_END = TW'(BIT_CLKS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    data_q, data_nx;
  logic          dir_q, dir_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    idx_q, idx_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      data_q <= '0;
      dir_q  <= 1'b0;
      timer  <= '0;
      idx_q  <= '0;
    end else begin
      state  <= state_nx;
      data_q <= data_nx;
      dir_q  <= dir_nx;
      timer  <= timer_nx;
      idx_q  <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    dir_nx   = dir_q;
    timer_nx = timer;
    idx_nx   = idx_q;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          data_nx  = in_data;
          dir_nx   = in_msb_first;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nx = S_HOLD;
        timer_nx = '0;
        idx_nx   = '0;
      end
      S_HOLD: begin
        timer_nx = timer + TW'(1);
        if (timer == T_END)
          state_nx = (idx_q == 3'd7) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        state_nx = S_HOLD;
        timer_nx = '0;
        idx_nx   = idx_q + 3'd1;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // cancel wins over every other transition
    if (abort && state != S_IDLE)
      state_nx = S_IDLE;
  end

  always_comb begin
    m = 2'd0;
    unique case (1'b1)
      (state == S_LOAD):  m = 2'd3;
      (state == S_SHIFT): m = dir_q ? 2'd2 : 2'd1;
      default:            m = 2'd0;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign par_in    = data_q;
  assign sl        = FILL;
  assign sr        = FILL;
  assign ser_out   = dir_q ? sr_q[7] : sr_q[0];
  assign ser_valid = (state == S_HOLD) ||
                     (state == S_SHIFT) ||
                     (state == S_DONE);
  assign bit_start = (state == S_HOLD) && (timer == '0);
  assign bit_idx   = idx_q;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed bench for shift_seq with a shift register model.
// Two instances: BIT_CLKS=4 (main) and BIT_CLKS=2 (short slots).
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         acc[$];
  logic       sb[$];
  logic       sb2[$];

  logic       v0 = 1'b0, msb0 = 1'b0, ab0 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic       rdy0, sl0, sr0, so0, sv0, bs0, busy0, dn0;
  logic [1:0] m0;
  logic [7:0] par0, q0;
  logic [2:0] bi0;

  logic       v2 = 1'b0, msb2 = 1'b0, ab2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       rdy2, sl2, sr2, so2, sv2, bs2, busy2, dn2;
  logic [1:0] m2;
  logic [7:0] par2, q2;
  logic [2:0] bi2;

  always #5 clk = ~clk;

  shift_seq #(.BIT_CLKS(4), .FILL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v0), .in_ready(rdy0),
    .in_data(d0), .in_msb_first(msb0),
    .abort(ab0), .sr_q(q0),
    .m(m0), .par_in(par0), .sl(sl0), .sr(sr0),
    .ser_out(so0), .ser_valid(sv0),
    .bit_start(bs0), .bit_idx(bi0),
    .busy(busy0), .done(dn0)
  );

  shift_seq #(.BIT_CLKS(2), .FILL(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .in_msb_first(msb2),
    .abort(ab2), .sr_q(q2),
    .m(m2), .par_in(par2), .sl(sl2), .sr(sr2),
    .ser_out(so2), .ser_valid(sv2),
    .bit_start(bs2), .bit_idx(bi2),
    .busy(busy2), .done(dn2)
  );

  // universal shift register models (no reset)
  always @(posedge clk) begin
    case (m0)
      2'd1:    q0 <= {sl0, q0[7:1]};
      2'd2:    q0 <= {q0[6:0], sr0};
      2'd3:    q0 <= par0;
      default: q0 <= q0;
    endcase
    case (m2)
      2'd1:    q2 <= {sl2, q2[7:1]};
      2'd2:    q2 <= {q2[6:0], sr2};
      2'd3:    q2 <= par2;
      default: q2 <= q2;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && v0 && rdy0) acc.push_back(cyc);

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit=2000000ns", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic msb,
                      input bit keep);
    v0 = 1'b1;
    d0 = d;
    msb0 = msb;
    for (int i = 0; i < 200 && !rdy0; i++) step();
    chk("send_rdy", 32'(rdy0), 32'd1);
    for (int i = 0; i < 8; i++)
      sb.push_back(msb ? d[7-i] : d[i]);
    step();
    if (!keep) v0 = 1'b0;
  endtask

  // walk one full byte on u0 from the LOAD cycle to the IDLE cycle
  task automatic follow(input logic [7:0] d, input logic msb);
    logic       cur;
    logic [7:0] eq;
    logic [1:0] em;
    int         slot, pos;
    cur = 1'bx;
    for (int k = 1; k <= 34; k++) begin
      if (k == 1) begin
        chk("load_m", 32'(m0), 32'd3);
        chk("load_sv", 32'(sv0), 32'd0);
        chk("load_rdy", 32'(rdy0), 32'd0);
        chk("load_busy", 32'(busy0), 32'd1);
      end else if (k <= 33) begin
        slot = (k - 2) / 4;
        pos  = (k - 2) % 4;
        chk("bit_start", 32'(bs0), 32'(pos == 0));
        if (pos == 0) begin
          if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
          else cur = sb.pop_front();
          eq = msb ? (d << slot) : (d >> slot);
          chk("reg_q", 32'(q0), 32'(eq));
        end
        chk("ser_out", 32'(so0), 32'(cur));
        chk("ser_valid", 32'(sv0), 32'd1);
        chk("bit_idx", 32'(bi0), 32'(slot));
        em = (pos == 3 && slot < 7) ? (msb ? 2'd2 : 2'd1) : 2'd0;
        chk("m_seq", 32'(m0), 32'(em));
        chk("done", 32'(dn0), 32'(k == 33));
        chk("busy", 32'(busy0), 32'd1);
      end else begin
        chk("end_rdy", 32'(rdy0), 32'd1);
        chk("end_busy", 32'(busy0), 32'd0);
        chk("end_done", 32'(dn0), 32'd0);
        chk("end_sv", 32'(sv0), 32'd0);
        chk("end_m", 32'(m0), 32'd0);
      end
      chk("par_in", 32'(par0), 32'(d));
      if (k < 34) step();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 32'(rdy0), 32'd1);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_m"}, 32'(m0), 32'd0);
    chk({tag, "_par"}, 32'(par0), 32'd0);
    chk({tag, "_idx"}, 32'(bi0), 32'd0);
    chk({tag, "_sv"}, 32'(sv0), 32'd0);
    chk({tag, "_bs"}, 32'(bs0), 32'd0);
    chk({tag, "_done"}, 32'(dn0), 32'd0);
    chk({tag, "_sl"}, 32'(sl0), 32'd0);
    chk({tag, "_sr"}, 32'(sr0), 32'd0);
  endtask

  initial begin
    logic cur2;
    bit   hit;
    int   slot, pos;

    step();
    step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // LSB first and MSB first
    send(8'h0F, 1'b0, 1'b0);
    follow(8'h0F, 1'b0);
    send(8'h0F, 1'b1, 1'b0);
    follow(8'h0F, 1'b1);

    // back-to-back with in_valid held
    send(8'hA5, 1'b0, 1'b1);
    d0 = 8'h5A;
    follow(8'hA5, 1'b0);
    send(8'h5A, 1'b1, 1'b0);
    if (acc.size() >= 2)
      chk("b2b_gap", 32'(acc[$] - acc[$-1]), 32'd34);
    else
      chk("b2b_cnt", 32'(acc.size()), 32'd2);
    follow(8'h5A, 1'b1);

    // vacated bits take FILL
    send(8'hFF, 1'b1, 1'b0);
    follow(8'hFF, 1'b1);

    // abort during bit 3
    send(8'h3C, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (bs0 && bi0 == 3'd3) hit = 1'b1;
      else step();
    end
    chk("abort_reach", 32'(hit), 32'd1);
    step();
    ab0 = 1'b1;
    step();
    ab0 = 1'b0;
    chk("abort_rdy", 32'(rdy0), 32'd1);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_sv", 32'(sv0), 32'd0);
    chk("abort_m", 32'(m0), 32'd0);
    chk("abort_done", 32'(dn0), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ab_idle_done", 32'(dn0), 32'd0);
      chk("ab_idle_sv", 32'(sv0), 32'd0);
      chk("ab_idle_m", 32'(m0), 32'd0);
    end
    sb.delete();
    send(8'h96, 1'b1, 1'b0);
    follow(8'h96, 1'b1);

    // asynchronous reset mid-slot
    send(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    step();
    step();
    rst_n = 1'b1;
    sb.delete();
    step();
    send(8'h81, 1'b0, 1'b0);
    follow(8'h81, 1'b0);

    // BIT_CLKS = 2 instance
    v2 = 1'b1;
    d2 = 8'hB4;
    msb2 = 1'b1;
    for (int i = 0; i < 50 && !rdy2; i++) step();
    chk("u2_rdy", 32'(rdy2), 32'd1);
    for (int i = 0; i < 8; i++) sb2.push_back(d2[7-i]);
    step();
    v2 = 1'b0;
    cur2 = 1'bx;
    for (int k = 1; k <= 18; k++) begin
      if (k >= 2 && k <= 17) begin
        slot = (k - 2) / 2;
        pos  = (k - 2) % 2;
        chk("u2_bs", 32'(bs2), 32'(pos == 0));
        if (pos == 0) begin
          if (sb2.size() == 0) chk("u2_sb_empty", 32'd1, 32'd0);
          else cur2 = sb2.pop_front();
        end
        chk("u2_ser", 32'(so2), 32'(cur2));
        chk("u2_idx", 32'(bi2), 32'(slot));
      end
      chk("u2_done", 32'(dn2), 32'(k == 17));
      if (k == 18) chk("u2_end_rdy", 32'(rdy2), 32'd1);
      if (k < 18) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
